// File: rtl/ej3_sweep_ctrl_pkg.sv
// Shared definitions for the not-exactly-two-high sweep sequencer.
//   Provides vector/table/count widths, the FSM state encoding, the default
//   expected truth table and a state decode helper.
package ej3_sweep_ctrl_pkg;

  localparam int unsigned VEC_W = 4;
  localparam int unsigned TT_W  = 16;
  localparam int unsigned ZC_W  = 5;
  localparam int unsigned CNT_W = 4;

  // R = 0 exactly at vectors 3,5,6,9,10,12
  localparam logic [TT_W-1:0] EXPECT_TT_DEF = 16'hE997;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // States during which a run is in progress
  function automatic logic is_busy(input state_t s);
    return (s == ST_APPLY) || (s == ST_SETTLE) || (s == ST_SAMPLE);
  endfunction

endpackage

// File: rtl/ej3_settle_cnt.sv
// Settle-time counter: loadable 4-bit down-counter with a zero flag.
//   clk, reset : clock, synchronous active-high reset
//   load       : load load_val (has priority over dec)
//   dec        : decrement while non-zero
//   load_val   : reload value
//   zero_c     : combinational flag, count == 0
module ej3_settle_cnt
  import ej3_sweep_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt;

  // Count register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/ej3_sweep_ctrl.sv
// Sweep sequencer for the 4-input not-exactly-two-high evaluator.
// Drives vectors 0..15 (or one selected vector) to the evaluator, waits
// SETTLE_CYC cycles, samples R into a truth table, counts zeros and flags
// pass against EXPECT_TT.
//   clk, reset : clock, synchronous active-high reset
//   start      : request a run (honoured in IDLE/DONE)
//   abort      : cancel a run in progress; wins over start
//   single     : with start, evaluate only vec_sel
//   vec_sel    : single-mode vector {a,b,c,d}
//   r_in       : evaluator output R
//   vec_out    : vector driven to the evaluator
//   busy       : run in progress
//   done       : run completed (level)
//   tt         : captured truth table, bit i = R for vector i
//   zero_cnt   : number of sampled vectors with R = 0
//   pass       : done, full sweep and tt == EXPECT_TT
module ej3_sweep_ctrl
  import ej3_sweep_ctrl_pkg::*;
#(
  parameter int unsigned      SETTLE_CYC = 1,
  parameter logic [TT_W-1:0]  EXPECT_TT  = EXPECT_TT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             single,
  input  logic [VEC_W-1:0] vec_sel,
  input  logic             r_in,
  output logic [VEC_W-1:0] vec_out,
  output logic             busy,
  output logic             done,
  output logic [TT_W-1:0]  tt,
  output logic [ZC_W-1:0]  zero_cnt,
  output logic             pass
);

  // Loading SETTLE_CYC-1 and leaving on zero gives exactly SETTLE_CYC cycles
  localparam logic [CNT_W-1:0] SETTLE_LOAD =
    (SETTLE_CYC == 0) ? '0 : CNT_W'(SETTLE_CYC - 1);
  localparam logic             HAS_SETTLE  = (SETTLE_CYC != 0);

  state_t           state, state_n;
  logic [VEC_W-1:0] idx, idx_n;
  logic             single_q, single_n;
  logic [VEC_W-1:0] vec_n;
  logic [TT_W-1:0]  tt_n;
  logic [ZC_W-1:0]  zc_n;
  logic             busy_n, done_n, pass_n;
  logic             cnt_load, cnt_dec, cnt_zero;

  ej3_settle_cnt u_settle (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (SETTLE_LOAD),
    .zero_c   (cnt_zero)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      idx      <= '0;
      single_q <= 1'b0;
      vec_out  <= '0;
      tt       <= '0;
      zero_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      single_q <= single_n;
      vec_out  <= vec_n;
      tt       <= tt_n;
      zero_cnt <= zc_n;
      busy     <= busy_n;
      done     <= done_n;
      pass     <= pass_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    single_n = single_q;
    vec_n    = vec_out;
    tt_n     = tt;
    zc_n     = zero_cnt;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start && !abort) begin
          single_n = single;
          idx_n    = single ? vec_sel : '0;
          zc_n     = '0;
          if (single) begin
            tt_n[vec_sel] = 1'b0;
          end else begin
            tt_n = '0;
          end
          state_n = ST_APPLY;
        end else if (start && abort) begin
          state_n = ST_IDLE;
        end
      end

      ST_APPLY: begin
        if (abort) begin
          state_n = ST_IDLE;
        end else begin
          vec_n    = idx;
          cnt_load = 1'b1;
          state_n  = HAS_SETTLE ? ST_SETTLE : ST_SAMPLE;
        end
      end

      ST_SETTLE: begin
        if (abort) begin
          state_n = ST_IDLE;
        end else begin
          cnt_dec = 1'b1;
          if (cnt_zero) begin
            state_n = ST_SAMPLE;
          end
        end
      end

      ST_SAMPLE: begin
        // An aborted sample leaves the table untouched
        if (abort) begin
          state_n = ST_IDLE;
        end else begin
          tt_n[idx] = r_in;
          zc_n      = zero_cnt + ZC_W'(!r_in);
          // Stop at 15 before the increment so the wrap never drives a 17th vector
          if (single_q || (idx == VEC_W'(15))) begin
            state_n = ST_DONE;
          end else begin
            idx_n   = idx + VEC_W'(1);
            state_n = ST_APPLY;
          end
        end
      end

      default: state_n = ST_IDLE;
    endcase

    busy_n = is_busy(state_n);
    done_n = (state_n == ST_DONE);
    pass_n = done_n && !single_n && (tt_n == EXPECT_TT);
  end

endmodule

// File: tb/tb_ej3_sweep_ctrl.sv
module tb_ej3_sweep_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, abort, single, stuck;
  logic [3:0] vec_sel;
  logic       r_in;
  logic [3:0] vec_out;
  logic       busy, done, pass;
  logic [15:0] tt;
  logic [4:0] zero_cnt;

  logic       start0, abort0, single0, r_in0;
  logic [3:0] vec_sel0, vec_out0;
  logic       busy0, done0, pass0;
  logic [15:0] tt0;
  logic [4:0] zero_cnt0;

  int total = 0;
  int bad   = 0;
  logic [15:0] tt_m;

  always #5 clk = ~clk;

  // Behavioural evaluators
  assign r_in  = stuck ? 1'b1 : ($countones(vec_out) != 2);
  assign r_in0 = ($countones(vec_out0) != 2);

  ej3_sweep_ctrl #(.SETTLE_CYC(1)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .single(single),
    .vec_sel(vec_sel), .r_in(r_in), .vec_out(vec_out), .busy(busy),
    .done(done), .tt(tt), .zero_cnt(zero_cnt), .pass(pass)
  );

  ej3_sweep_ctrl #(.SETTLE_CYC(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .abort(abort0), .single(single0),
    .vec_sel(vec_sel0), .r_in(r_in0), .vec_out(vec_out0), .busy(busy0),
    .done(done0), .tt(tt0), .zero_cnt(zero_cnt0), .pass(pass0)
  );

  // Reference rule: R is 0 iff exactly two of the four bits are set
  function automatic logic ref_r(input int v, input logic stk);
    int ones = 0;
    for (int b = 0; b < 4; b++) ones += (v >> b) & 1;
    return stk ? 1'b1 : (ones != 2);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run(input logic sgl, input logic [3:0] v,
                     output int busy_cyc, output logic ok);
    start = 1'b1; single = sgl; vec_sel = v;
    tick();
    start = 1'b0;
    busy_cyc = 0; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin ok = 1'b1; break; end
      if (busy) busy_cyc++;
      tick();
    end
    total++;
    if (!ok) begin bad++; $display("FAIL run_timeout done=%0b required 1", done); end
  endtask

  task automatic run0(output int busy_cyc, output logic ok);
    start0 = 1'b1; single0 = 1'b0; vec_sel0 = 4'd0;
    tick();
    start0 = 1'b0;
    busy_cyc = 0; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done0) begin ok = 1'b1; break; end
      if (busy0) busy_cyc++;
      tick();
    end
    total++;
    if (!ok) begin bad++; $display("FAIL run0_timeout done=%0b required 1", done0); end
  endtask

  task automatic check_outputs_zero(input string tag);
    total++;
    if ({vec_out, busy, done, tt, zero_cnt, pass} !== 28'd0) begin
      bad++;
      $display("FAIL %s_outputs vec=%h busy=%b done=%b tt=%h zc=%0d pass=%b required all 0",
               tag, vec_out, busy, done, tt, zero_cnt, pass);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check_outputs_zero("reset");
    total++;
    if ({vec_out0, busy0, done0, tt0, zero_cnt0, pass0} !== 28'd0) begin
      bad++; $display("FAIL reset0_outputs tt=%h busy=%b required 0", tt0, busy0);
    end
    tt_m = 16'h0000;
  endtask

  task automatic test_reset_mid_sweep();
    logic moved;
    start = 1'b1; single = 1'b0;
    tick();
    start = 1'b0;
    repeat (20) tick();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL mid_sweep_busy busy=%b required 1", busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_outputs_zero("reset_mid");
    moved = 1'b0;
    repeat (6) begin tick(); if (vec_out !== 4'd0 || busy !== 1'b0) moved = 1'b1; end
    total++;
    if (moved) begin bad++; $display("FAIL reset_hold vec=%h busy=%b required 0 0", vec_out, busy); end
    tt_m = 16'h0000;
  endtask

  task automatic check_run(input string tag, input int bc, input int bc_exp,
                           input logic [4:0] zc_exp, input logic pass_exp);
    total++;
    if (bc != bc_exp) begin bad++; $display("FAIL %s_busy_cycles got=%0d required %0d", tag, bc, bc_exp); end
    total++;
    if (tt !== tt_m) begin bad++; $display("FAIL %s_tt got=%h required %h", tag, tt, tt_m); end
    total++;
    if (zero_cnt !== zc_exp) begin bad++; $display("FAIL %s_zero_cnt got=%0d required %0d", tag, zero_cnt, zc_exp); end
    total++;
    if (pass !== pass_exp) begin bad++; $display("FAIL %s_pass got=%b required %b", tag, pass, pass_exp); end
  endtask

  task automatic model_full(input logic stk, output logic [4:0] zc);
    zc = 5'd0;
    for (int i = 0; i < 16; i++) begin
      tt_m[i] = ref_r(i, stk);
      if (!tt_m[i]) zc++;
    end
  endtask

  task automatic test_full_sweep();
    int bc; logic ok; logic [4:0] zc;
    stuck = 1'b0;
    run(1'b0, 4'd0, bc, ok);
    model_full(1'b0, zc);
    check_run("full", bc, 48, zc, 1'b1);
    total++;
    if (tt !== 16'hE997 || zero_cnt !== 5'd6) begin
      bad++; $display("FAIL full_const tt=%h zc=%0d required e997 6", tt, zero_cnt);
    end
  endtask

  task automatic test_stuck();
    int bc; logic ok; logic [4:0] zc;
    stuck = 1'b1;
    run(1'b0, 4'd0, bc, ok);
    stuck = 1'b0;
    model_full(1'b1, zc);
    check_run("stuck", bc, 48, zc, 1'b0);
  endtask

  task automatic test_single();
    int bc; logic ok;
    run(1'b1, 4'b0101, bc, ok);
    tt_m[5] = ref_r(5, 1'b0);
    check_run("single", bc, 3, 5'd1, 1'b0);
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL single_done got=%b required 1", done); end
  endtask

  task automatic test_abort();
    logic found; logic [4:0] zc;
    start = 1'b1; single = 1'b0;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (vec_out == 4'd7) begin found = 1'b1; break; end
      tick();
    end
    total++;
    if (!found) begin bad++; $display("FAIL abort_wait vec=%h required 7", vec_out); end
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tt_m = 16'h0000; zc = 5'd0;
    for (int i = 0; i < 7; i++) begin
      tt_m[i] = ref_r(i, 1'b0);
      if (!tt_m[i]) zc++;
    end
    total++;
    if ({busy, done, pass} !== 3'b000) begin
      bad++; $display("FAIL abort_flags busy=%b done=%b pass=%b required 000", busy, done, pass);
    end
    total++;
    if (tt !== tt_m || zero_cnt !== zc) begin
      bad++; $display("FAIL abort_partial tt=%h zc=%0d required %h %0d", tt, zero_cnt, tt_m, zc);
    end
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    tick();
    total++;
    if ({busy, done} !== 2'b00 || tt !== tt_m) begin
      bad++; $display("FAIL start_abort_idle busy=%b done=%b tt=%h required 0 0 %h", busy, done, tt, tt_m);
    end
  endtask

  task automatic test_random();
    int bc; logic ok; logic sgl, stk; logic [3:0] v; logic [4:0] zc; logic pe;
    for (int n = 0; n < 10; n++) begin
      sgl = 1'($urandom_range(0, 1));
      stk = ($urandom_range(0, 3) == 0);
      v   = 4'($urandom_range(0, 15));
      stuck = stk;
      run(sgl, v, bc, ok);
      stuck = 1'b0;
      if (sgl) begin
        tt_m[v] = ref_r(int'(v), stk);
        zc = tt_m[v] ? 5'd0 : 5'd1;
      end else begin
        model_full(stk, zc);
      end
      pe = !sgl && (tt_m == 16'hE997);
      check_run($sformatf("rand%0d", n), bc, sgl ? 3 : 48, zc, pe);
    end
  endtask

  task automatic test_no_settle();
    int bc; logic ok; logic found;
    run0(bc, ok);
    total++;
    if (bc != 32) begin bad++; $display("FAIL nosettle_busy_cycles got=%0d required 32", bc); end
    total++;
    if (tt0 !== 16'hE997 || zero_cnt0 !== 5'd6 || pass0 !== 1'b1) begin
      bad++; $display("FAIL nosettle_result tt=%h zc=%0d pass=%b required e997 6 1", tt0, zero_cnt0, pass0);
    end
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    total++;
    if (tt0 !== 16'h0000 || busy0 !== 1'b1 || done0 !== 1'b0) begin
      bad++; $display("FAIL restart tt=%h busy=%b done=%b required 0000 1 0", tt0, busy0, done0);
    end
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done0) begin found = 1'b1; break; end
      tick();
    end
    total++;
    if (!found || tt0 !== 16'hE997) begin
      bad++; $display("FAIL restart_result done=%b tt=%h required 1 e997", done0, tt0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; single = 1'b0; vec_sel = 4'd0; stuck = 1'b0;
    start0 = 1'b0; abort0 = 1'b0; single0 = 1'b0; vec_sel0 = 4'd0;
    test_reset();
    test_reset_mid_sweep();
    test_full_sweep();
    test_stuck();
    test_single();
    test_abort();
    test_random();
    test_no_settle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
